// File: rtl/acc_cpu_core_if.sv
// Memory bus between acc_cpu_core (master) and the instruction/data memory (slave).
// Handshake: the master raises mem_req with adrs, rw and dout stable and keeps
// them stable until the slave answers. The access completes in the cycle where
// mem_req and mem_ack are both high; mem_ack while mem_req is low means nothing.
interface acc_cpu_core_if #(
  parameter int DW = 8,
  parameter int AW = 8
);
  logic [DW+7:0] din;
  logic          mem_ack;
  logic          mem_req;
  logic          rw;
  logic [AW-1:0] adrs;
  logic [DW-1:0] dout;

  modport master (input din, mem_ack, output mem_req, rw, adrs, dout);
  modport slave  (output din, mem_ack, input mem_req, rw, adrs, dout);
endinterface

// File: rtl/acc_cpu_core.sv
// Parametrised accumulator CPU core: IR, PC, accumulator, ALU, registered
// carry/zero flags and a START/FETCH/EXEC/MEM/HALT control FSM talking to
// memory through a req/ack bus with arbitrary wait states.
module acc_cpu_core #(
  parameter int            DW       = 8,
  parameter int            AW       = 8,
  parameter logic [AW-1:0] RESET_PC = '0
) (
  input  logic           clk,
  input  logic           clr,
  acc_cpu_core_if.master bus,
  output logic           carry,
  output logic           zero,
  output logic           halted,
  output logic [2:0]     dbg_state
);

  if (AW < 1 || AW > DW) begin : g_bad_aw
    $error("acc_cpu_core: AW must be in 1..DW");
  end

  typedef enum logic [2:0] {
    S_START = 3'd0,
    S_FETCH = 3'd1,
    S_EXEC  = 3'd2,
    S_MEM   = 3'd3,
    S_HALT  = 3'd4
  } state_t;

  localparam logic [7:0] OP_LDI  = 8'h01;
  localparam logic [7:0] OP_LDA  = 8'h02;
  localparam logic [7:0] OP_STA  = 8'h03;
  localparam logic [7:0] OP_ADD  = 8'h04;
  localparam logic [7:0] OP_ADDI = 8'h05;
  localparam logic [7:0] OP_SUB  = 8'h06;
  localparam logic [7:0] OP_AND  = 8'h07;
  localparam logic [7:0] OP_OR   = 8'h08;
  localparam logic [7:0] OP_XOR  = 8'h09;
  localparam logic [7:0] OP_JMP  = 8'h0A;
  localparam logic [7:0] OP_JZ   = 8'h0B;
  localparam logic [7:0] OP_JC   = 8'h0C;
  localparam logic [7:0] OP_HLT  = 8'h0D;

  state_t        state, state_nxt;
  logic [AW-1:0] pc, pc_nxt;
  logic [DW+7:0] ir, ir_nxt;
  logic [DW-1:0] acc, acc_nxt;
  logic          carry_nxt, zero_nxt;
  logic [DW:0]   alu;

  logic [7:0]    opcode;
  logic [DW-1:0] operand;
  logic [DW-1:0] mdata;

  assign opcode    = ir[DW+7:DW];
  assign operand   = ir[DW-1:0];
  assign mdata     = bus.din[DW-1:0];
  assign bus.dout  = acc;
  assign dbg_state = state;

  // State and datapath registers; clr abandons any access in flight.
  always_ff @(posedge clk) begin
    if (clr) begin
      state <= S_START;
      pc    <= RESET_PC;
      ir    <= '0;
      acc   <= '0;
      carry <= 1'b0;
      zero  <= 1'b0;
    end else begin
      state <= state_nxt;
      pc    <= pc_nxt;
      ir    <= ir_nxt;
      acc   <= acc_nxt;
      carry <= carry_nxt;
      zero  <= zero_nxt;
    end
  end

  // Next-state, datapath updates and bus outputs; ALU result carries the flag in bit DW.
  always_comb begin
    state_nxt   = state;
    pc_nxt      = pc;
    ir_nxt      = ir;
    acc_nxt     = acc;
    carry_nxt   = carry;
    zero_nxt    = zero;
    alu         = '0;
    bus.mem_req = 1'b0;
    bus.rw      = 1'b1;
    bus.adrs    = pc;
    halted      = 1'b0;

    case (state)
      S_START: state_nxt = S_FETCH;

      S_FETCH: begin
        bus.mem_req = 1'b1;
        if (bus.mem_ack) begin
          ir_nxt    = bus.din;
          pc_nxt    = pc + AW'(1);
          state_nxt = S_EXEC;
        end
      end

      S_EXEC: begin
        state_nxt = S_FETCH;
        case (opcode)
          OP_LDI: begin
            acc_nxt  = operand;
            zero_nxt = (operand == '0);
          end
          OP_ADDI: begin
            alu       = {1'b0, acc} + {1'b0, operand};
            acc_nxt   = alu[DW-1:0];
            carry_nxt = alu[DW];
            zero_nxt  = (alu[DW-1:0] == '0);
          end
          OP_JMP: pc_nxt = operand[AW-1:0];
          OP_JZ:  if (zero)  pc_nxt = operand[AW-1:0];
          OP_JC:  if (carry) pc_nxt = operand[AW-1:0];
          OP_HLT: state_nxt = S_HALT;
          OP_LDA, OP_STA, OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR: state_nxt = S_MEM;
          default: ;
        endcase
      end

      S_MEM: begin
        bus.mem_req = 1'b1;
        bus.adrs    = operand[AW-1:0];
        bus.rw      = (opcode != OP_STA);
        case (opcode)
          OP_ADD:  alu = {1'b0, acc} + {1'b0, mdata};
          OP_SUB:  alu = {1'b0, acc} - {1'b0, mdata};
          OP_AND:  alu = {1'b0, acc & mdata};
          OP_OR:   alu = {1'b0, acc | mdata};
          OP_XOR:  alu = {1'b0, acc ^ mdata};
          default: alu = {1'b0, mdata};
        endcase
        if (bus.mem_ack) begin
          state_nxt = S_FETCH;
          if (opcode != OP_STA) begin
            acc_nxt  = alu[DW-1:0];
            zero_nxt = (alu[DW-1:0] == '0);
            if (opcode != OP_LDA) carry_nxt = alu[DW];
          end
        end
      end

      S_HALT: halted = 1'b1;

      default: state_nxt = S_START;
    endcase
  end

endmodule

// File: doc/acc_cpu_core.md
Name: acc_cpu_core

Overview:
- Parametrised next-generation accumulator CPU core. Datapath is DW bits wide, address space is AW bits.
- Integrates the IR, PC, accumulator, ALU, registered flags and a multicycle fetch/execute FSM.
- Adds what the fixed 8-bit core lacks: a req/ack memory handshake with arbitrary wait states, conditional branches on registered flags, and a HALT state.
- Sits between the instruction/data memory and the system top level.

Parameters:
- DW, 8, data/accumulator width. Instruction word is DW+8 bits.
- AW, 8, address width. Legal range 1..DW; elaboration error otherwise.
- RESET_PC, 0, PC value loaded on reset; width AW.

Ports:
- clk  in  1  clock, rising edge
- clr  in  1  reset, synchronous, active-high
- din  in  DW+8  memory read data. Fetch uses all bits (opcode din[DW+7:DW], operand din[DW-1:0]); data reads use din[DW-1:0]
- mem_ack  in  1  memory completes the current access in this cycle
- mem_req  out  1  access request; adrs, rw and dout stable while high
- rw  out  1  1 = read, 0 = write
- adrs  out  AW  memory address
- dout  out  DW  accumulator value, always driven; it is the write data
- carry  out  1  registered carry/borrow flag
- zero  out  1  registered zero flag
- halted  out  1  high in HALT state

Behaviour:
- Reset: clr sampled high at a clock edge sets state=START, pc=RESET_PC, ir=0, acc=0, carry=0, zero=0. Outputs after that edge: mem_req=0, rw=1, adrs=RESET_PC, halted=0.
- Reset mid-access abandons the access; mem_ack during clr is ignored.
- States:
  - START: mem_req=0, then -> FETCH.
  - FETCH: mem_req=1, rw=1, adrs=pc. On mem_ack: ir<=din, pc<=pc+1 (mod 2^AW), -> EXEC. Otherwise hold.
  - EXEC: mem_req=0, adrs=pc. Non-memory ops complete here and go -> FETCH (HLT -> HALT). Memory ops -> MEM.
  - MEM: mem_req=1, adrs=operand[AW-1:0], rw=0 for STA, else 1. On mem_ack: complete and -> FETCH. Otherwise hold.
  - HALT: mem_req=0, halted=1, adrs=pc. Stays until clr.
- Handshake rules:
  - mem_req is high only in FETCH and MEM.
  - An access completes in the cycle where mem_req=1 and mem_ack=1, so ack in the same cycle as req means zero wait.
  - mem_ack while mem_req=0 is ignored.
  - req never drops before ack.
- Latency with zero wait: non-memory instructions take 2 cycles, memory instructions 3. Each wait cycle adds 1.
- Opcodes (ir[DW+7:DW]). Operand is op = ir[DW-1:0]; M is din[DW-1:0] captured at MEM ack.
  - 0x00 NOP.
  - 0x01 LDI: acc=op.
  - 0x02 LDA: acc=M.
  - 0x03 STA: writes acc.
  - 0x04 ADD: acc=acc+M.
  - 0x05 ADDI: acc=acc+op.
  - 0x06 SUB: acc=acc-M.
  - 0x07 AND: acc=acc&M.
  - 0x08 OR: acc=acc|M.
  - 0x09 XOR: acc=acc^M.
  - 0x0A JMP: pc=op[AW-1:0].
  - 0x0B JZ: jump if zero=1.
  - 0x0C JC: jump if carry=1.
  - 0x0D HLT.
  - All other opcodes execute as NOP.
- Flag rules:
  - ADD/ADDI: carry = bit DW of the (DW+1)-bit sum.
  - SUB: carry=1 on borrow (acc < M unsigned).
  - AND/OR/XOR: carry=0.
  - LDI/LDA: carry unchanged.
  - zero = (new acc == 0) for LDI, LDA and all ALU ops.
  - STA, NOP, jumps and HLT leave both flags unchanged.
- Timing of updates: acc and flags update at the completing edge (EXEC, or MEM ack). Branches test the flag values registered before the branch's EXEC cycle.
- PC wraps from 2^AW-1 to 0. A jump target overrides the incremented PC.

Test Plan:
- Reset/boot, RESET_PC=0x10: hold clr 2 cycles, then release. Required: mem_req=0 for one cycle (START), then mem_req=1, adrs=0x10, rw=1.
- Zero-wait program, DW=8: LDI 0xF0; ADDI 0x20; JC 0x40. Required: acc=0x10, carry=1, zero=0, next fetch adrs=0x40. Total 6 cycles from first FETCH.
- Wait states: LDA 0x33 with 3 cycles of no ack on the data read. Required: mem_req held high with adrs=0x33 for 4 cycles; acc=M after ack; zero set when M=0.
- STA/SUB: acc=0x05; SUB with M=0x07 gives acc=0xFE, carry=1. Then STA 0x80. Required: rw=0, adrs=0x80, dout=0xFE during MEM.
- Boundaries: pc=0xFF with NOP fetched wraps pc to 0x00. Illegal opcode 0x7F behaves as NOP. HLT gives halted=1, mem_req=0, and ignores mem_ack until clr.
- clr asserted during a MEM wait. Required: mem_req=0 after that edge; acc and flags cleared; restart at RESET_PC.
